demux_18_seq: RTL and testbench
===============================

DEMUX_18_SEQ -- requirements
Module: demux_18_seq

Interface
REQ-001 The block SHALL have parameter RST_VAL, default 8'b00000000, the value loaded into y at reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge only.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port din, input, 1 bit: the serial data bit.
REQ-005 The block SHALL have port din_valid, input, 1 bit: din is sampled only when this is high.
REQ-006 The block SHALL have port sof, input, 1 bit: start of frame; it qualifies the first bit of a frame and is used only when din_valid is high.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 selects sequential (deserialize) mode, 1 selects addressed mode.
REQ-008 The block SHALL have port s, input, [1:3]: lane select used in addressed mode; 3'b000 selects lane 1 and 3'b111 selects lane 8.
REQ-009 The block SHALL have port y, output, [1:8]: registered lane outputs.
REQ-010 The block SHALL have port cnt, output, [1:3]: the index of the next lane to fill in sequential mode.
REQ-011 The block SHALL have port frame_valid, output, 1 bit: a one-cycle pulse indicating y holds a newly completed frame.
REQ-012 The block SHALL have port err, output, 1 bit: a one-cycle pulse on frame abort.

Function
REQ-013 In sequential mode the block SHALL act as the inverse of an 8:1 mux driven by a 000..111 select count: the bit accepted at count k SHALL land in lane k+1, so the first bit goes to y[1] and the eighth to y[8].
REQ-014 The FSM SHALL have two states, IDLE and COLLECT, both used only when mode=0.
REQ-015 In IDLE, a cycle with din_valid=1 and sof=1 SHALL write din to shadow bit 1, set cnt=3'b001 and go to COLLECT.
REQ-016 In IDLE, a cycle with din_valid=1 and sof=0 SHALL discard the bit; cnt SHALL stay 3'b000 and err SHALL stay 0.
REQ-017 In COLLECT, a cycle with din_valid=1 and sof=0 SHALL write din to shadow bit cnt+1 and increment cnt.
REQ-018 In COLLECT, a cycle with din_valid=0 SHALL hold the state; the block SHALL have no timeout.
REQ-019 When the eighth bit is accepted (cnt=3'b111), on the same edge the block SHALL load y from the shadow bits plus the new bit, pulse frame_valid for exactly that following cycle, wrap cnt to 3'b000 and go to IDLE.
REQ-020 y SHALL change only on a frame completion (REQ-019) or an addressed write (REQ-023), never bit by bit during COLLECT.
REQ-021 In COLLECT, a cycle with din_valid=1 and sof=1 SHALL abort the current frame, pulse err, leave y unchanged, and restart with din as the new bit 1 (cnt=3'b001, state stays COLLECT).
REQ-022 A frame SHALL be able to start in the cycle in which frame_valid is high, giving back-to-back frames 8 accepted bits apart with no dead cycle.
REQ-023 In addressed mode (mode=1), each cycle with din_valid=1 SHALL write din to y[s+1] on that edge, leave the other lanes unchanged, ignore sof, keep frame_valid at 0, and hold cnt at 3'b000.
REQ-024 A change of mode from 0 to 1 while in COLLECT SHALL pulse err once, discard the shadow bits, and force IDLE with cnt=3'b000.
REQ-025 A change of mode in IDLE SHALL be silent, with no err pulse.
REQ-026 frame_valid and err SHALL never be high in the same cycle.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL set y=RST_VAL, cnt=3'b000, state=IDLE, frame_valid=0, err=0 and clear the shadow bits.
REQ-028 Reset SHALL take priority over all other inputs.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame with no err pulse.
REQ-030 The first frame after reset release SHALL require sof.

Verification
REQ-031 The bench SHALL drive, in mode=0, sof with the first bit, then 8 consecutive valid bits 0,1,0,0,1,1,0,1, and check y=8'b01001101 with frame_valid high for exactly 1 cycle.
REQ-032 The bench SHALL drive the same frame with din_valid=0 gaps of 1 to 3 cycles between bits, and check an identical y and frame_valid high for exactly 1 cycle.
REQ-033 The bench SHALL drive two back-to-back frames, 8'hA5 then 8'h3C, with no gap, and check frame_valid pulses 8 cycles apart, y=8'hA5 then y=8'h3C, and err never high.
REQ-034 The bench SHALL assert sof again after 5 bits of a frame, then complete 8 bits, and check err high for 1 cycle, y unchanged until completion, and y equal to the restarted frame.
REQ-035 The bench SHALL use mode=1 to write din=1 for s=3'b000 through 3'b111 from y=8'h00, and check y=8'hFF, frame_valid always 0 and cnt always 3'b000.
REQ-036 The bench SHALL assert rst after 4 bits of a frame, release it, then send a full frame, and check y=RST_VAL, cnt=3'b000 and no err after reset, followed by a correct capture.

Source files
------------

// File: rtl/demux_18_seq.sv
// Serial-to-parallel 1:8 demultiplexer with a sequential (frame) mode and an addressed (per-lane) mode.
// Sequential frames are staged in a shadow register so y only changes on frame completion.
//
// state   | meaning
// IDLE    | waiting for a valid bit qualified by sof to start a frame
// COLLECT | frame in progress; cnt holds the next lane to fill
module demux_18_seq #(
   parameter logic [7:0] RST_VAL = 8'b00000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       din_valid,
   input  logic       sof,
   input  logic       mode,
   input  logic [1:3] s,
   output logic [1:8] y,
   output logic [1:3] cnt,
   output logic       frame_valid,
   output logic       err
);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t      state_q;
   logic [1:7]  shadow_q;
   logic [2:0]  cnt_q;
   logic [1:8]  y_q;
   logic        fv_q;
   logic        err_q;

   logic [3:0]  lane_sel;
   logic [3:0]  lane_cnt;
   logic [1:8]  y_addr_d;
   logic [1:8]  frame_d;

   assign lane_sel = {1'b0, s} + 4'd1;
   assign lane_cnt = {1'b0, cnt_q} + 4'd1;
   assign frame_d  = {shadow_q, din};

   always_comb begin
      y_addr_d           = y_q;
      y_addr_d[lane_sel] = din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         cnt_q    <= 3'd0;
         y_q      <= RST_VAL;
         fv_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         fv_q  <= 1'b0;
         err_q <= 1'b0;
         if (mode) begin
            // Addressed mode: direct lane write; a frame in flight is abandoned with an error.
            if (din_valid) y_q <= y_addr_d;
            cnt_q   <= 3'd0;
            state_q <= IDLE;
            if (state_q == COLLECT) begin
               err_q    <= 1'b1;
               shadow_q <= '0;
            end
         end else if (din_valid) begin
            case (state_q)
               IDLE: begin
                  if (sof) begin
                     shadow_q[1] <= din;
                     cnt_q       <= 3'd1;
                     state_q     <= COLLECT;
                  end
               end
               COLLECT: begin
                  if (sof) begin
                     shadow_q[1] <= din;
                     cnt_q       <= 3'd1;
                     err_q       <= 1'b1;
                  end else if (cnt_q == 3'd7) begin
                     y_q     <= frame_d;
                     fv_q    <= 1'b1;
                     cnt_q   <= 3'd0;
                     state_q <= IDLE;
                  end else begin
                     shadow_q[lane_cnt] <= din;
                     cnt_q              <= cnt_q + 3'd1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign y           = y_q;
   assign cnt         = cnt_q;
   assign frame_valid = fv_q;
   assign err         = err_q;

endmodule

// File: tb/tb_demux_18_seq.sv
// Directed self-checking bench for demux_18_seq: frames, gaps, back-to-back, abort,
// addressed writes, mode switching and mid-frame reset.
module tb_demux_18_seq;

   localparam logic [7:0] RV = 8'h00;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       sof = 1'b0;
   logic       mode = 1'b0;
   logic [1:3] s = 3'd0;
   logic [1:8] y;
   logic [1:3] cnt;
   logic       frame_valid;
   logic       err;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int fv_seen = 0;
   int err_seen = 0;
   int overlap_seen = 0;
   int last_fv = 0;

   demux_18_seq #(.RST_VAL(RV)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
      .mode(mode), .s(s), .y(y), .cnt(cnt), .frame_valid(frame_valid), .err(err)
   );

   always #5 clk = ~clk;

   // One clock; outputs are sampled 1 ns after the edge and pulses are tallied.
   task automatic cyc();
      @(posedge clk);
      #1;
      cycle++;
      if (frame_valid) begin
         fv_seen++;
         last_fv = cycle;
      end
      if (err) err_seen++;
      if (frame_valid && err) overlap_seen++;
   endtask

   task automatic send_bit(input logic b, input logic sf);
      din = b;
      sof = sf;
      din_valid = 1'b1;
      cyc();
      din_valid = 1'b0;
      sof = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      checks++; if (y !== RV) begin errors++; $display("FAIL reset_y: got %h want %h", y, RV); end
      checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
      checks++; if (frame_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_pulses: fv=%b err=%b want 0 0", frame_valid, err); end
      rst = 1'b0;
   endtask

   task automatic test_seq();
      logic [7:0] f;
      f = 8'b01001101;
      fv_seen = 0; err_seen = 0;
      send_bit(1'b1, 1'b0);
      checks++; if (cnt !== 3'd0 || err_seen != 0) begin errors++; $display("FAIL idle_discard: cnt=%0d err_seen=%0d want 0 0", cnt, err_seen); end
      for (int i = 0; i < 8; i++) begin
         send_bit(f[7-i], i == 0);
         if (i == 3) begin
            checks++; if (y !== RV || cnt !== 3'd4) begin errors++; $display("FAIL seq_mid: y=%h cnt=%0d want %h 4", y, cnt, RV); end
         end
         if (i == 7) begin
            checks++; if (frame_valid !== 1'b1 || y !== f || cnt !== 3'd0) begin errors++; $display("FAIL seq_done: fv=%b y=%h cnt=%0d want 1 %h 0", frame_valid, y, cnt, f); end
         end
      end
      cyc();
      checks++; if (frame_valid !== 1'b0 || fv_seen != 1) begin errors++; $display("FAIL seq_pulse: fv=%b fv_seen=%0d want 0 1", frame_valid, fv_seen); end
   endtask

   task automatic test_gaps();
      logic [7:0] f;
      f = 8'b01001101;
      rst = 1'b1; cyc(); rst = 1'b0;
      fv_seen = 0;
      for (int i = 0; i < 8; i++) begin
         send_bit(f[7-i], i == 0);
         if (i < 7) repeat ((i % 3) + 1) cyc();
      end
      checks++; if (frame_valid !== 1'b1 || y !== f) begin errors++; $display("FAIL gaps_done: fv=%b y=%h want 1 %h", frame_valid, y, f); end
      cyc();
      checks++; if (fv_seen != 1 || y !== f) begin errors++; $display("FAIL gaps_pulse: fv_seen=%0d y=%h want 1 %h", fv_seen, y, f); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] fr [2];
      int t0;
      fr[0] = 8'hA5; fr[1] = 8'h3C;
      t0 = 0;
      fv_seen = 0; err_seen = 0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) send_bit(fr[k][7-i], i == 0);
         checks++; if (frame_valid !== 1'b1 || y !== fr[k]) begin errors++; $display("FAIL b2b_frame%0d: fv=%b y=%h want 1 %h", k, frame_valid, y, fr[k]); end
         if (k == 0) t0 = cycle;
      end
      cyc();
      checks++; if (last_fv - t0 != 8) begin errors++; $display("FAIL b2b_spacing: got %0d want 8", last_fv - t0); end
      checks++; if (fv_seen != 2 || err_seen != 0) begin errors++; $display("FAIL b2b_counts: fv_seen=%0d err_seen=%0d want 2 0", fv_seen, err_seen); end
   endtask

   task automatic test_abort();
      logic [7:0] f;
      f = 8'h96;
      fv_seen = 0; err_seen = 0;
      for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
      checks++; if (cnt !== 3'd5) begin errors++; $display("FAIL abort_pre: cnt=%0d want 5", cnt); end
      for (int i = 0; i < 8; i++) begin
         send_bit(f[7-i], i == 0);
         if (i == 0) begin
            checks++; if (err !== 1'b1 || y !== 8'h3C || cnt !== 3'd1) begin errors++; $display("FAIL abort_err: err=%b y=%h cnt=%0d want 1 3c 1", err, y, cnt); end
         end
         if (i == 1) begin
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_pulse: err=%b want 0", err); end
         end
         if (i == 6) begin
            checks++; if (y !== 8'h3C) begin errors++; $display("FAIL abort_hold: y=%h want 3c", y); end
         end
         if (i == 7) begin
            checks++; if (frame_valid !== 1'b1 || y !== f) begin errors++; $display("FAIL abort_done: fv=%b y=%h want 1 %h", frame_valid, y, f); end
         end
      end
      cyc();
      checks++; if (err_seen != 1 || fv_seen != 1) begin errors++; $display("FAIL abort_counts: err_seen=%0d fv_seen=%0d want 1 1", err_seen, fv_seen); end
   endtask

   task automatic test_addressed();
      logic [7:0] exp;
      rst = 1'b1; cyc(); rst = 1'b0;
      mode = 1'b1;
      fv_seen = 0;
      for (int k = 0; k < 8; k++) begin
         s = 3'(k);
         din = 1'b1;
         sof = k[0];
         din_valid = 1'b1;
         cyc();
         exp = 8'hFF << (7 - k);
         checks++; if (y !== exp || cnt !== 3'd0 || frame_valid !== 1'b0) begin errors++; $display("FAIL addr_s%0d: y=%h cnt=%0d fv=%b want %h 0 0", k, y, cnt, frame_valid, exp); end
      end
      din_valid = 1'b0; sof = 1'b0; din = 1'b0;
      cyc();
      checks++; if (y !== 8'hFF || fv_seen != 0) begin errors++; $display("FAIL addr_final: y=%h fv_seen=%0d want ff 0", y, fv_seen); end
   endtask

   task automatic test_mode_switch();
      mode = 1'b0;
      cyc();
      err_seen = 0;
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      checks++; if (cnt !== 3'd3 || err_seen != 0) begin errors++; $display("FAIL mode_pre: cnt=%0d err_seen=%0d want 3 0", cnt, err_seen); end
      mode = 1'b1;
      cyc();
      checks++; if (err !== 1'b1 || cnt !== 3'd0 || y !== 8'hFF) begin errors++; $display("FAIL mode_abort: err=%b cnt=%0d y=%h want 1 0 ff", err, cnt, y); end
      cyc();
      mode = 1'b0;
      cyc();
      send_bit(1'b1, 1'b0);
      checks++; if (err_seen != 1 || cnt !== 3'd0) begin errors++; $display("FAIL mode_idle: err_seen=%0d cnt=%0d want 1 0", err_seen, cnt); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] f;
      f = 8'h5A;
      err_seen = 0; fv_seen = 0;
      for (int i = 0; i < 4; i++) send_bit(f[7-i], i == 0);
      rst = 1'b1; din = 1'b1; sof = 1'b1; din_valid = 1'b1;
      cyc();
      rst = 1'b0; din_valid = 1'b0; sof = 1'b0;
      checks++; if (y !== RV || cnt !== 3'd0 || err !== 1'b0 || frame_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state: y=%h cnt=%0d err=%b fv=%b want %h 0 0 0", y, cnt, err, frame_valid, RV); end
      cyc();
      send_bit(1'b1, 1'b0);
      checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL rstmid_needsof: cnt=%0d want 0", cnt); end
      f = 8'hC3;
      for (int i = 0; i < 8; i++) send_bit(f[7-i], i == 0);
      checks++; if (frame_valid !== 1'b1 || y !== f) begin errors++; $display("FAIL rstmid_capture: fv=%b y=%h want 1 %h", frame_valid, y, f); end
      cyc();
      checks++; if (err_seen != 0 || fv_seen != 1) begin errors++; $display("FAIL rstmid_counts: err_seen=%0d fv_seen=%0d want 0 1", err_seen, fv_seen); end
   endtask

   initial begin
      test_reset();
      test_seq();
      test_gaps();
      test_back_to_back();
      test_abort();
      test_addressed();
      test_mode_switch();
      test_reset_mid();
      checks++; if (overlap_seen != 0) begin errors++; $display("FAIL fv_err_overlap: got %0d cycles want 0", overlap_seen); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
